// File: rtl/serial_receiver.sv
// Serial-in/parallel-out receiver: rebuilds an MSB-first SIZE-bit word from the
// transceiver line and hands it on through a valid/ack handshake.
module serial_receiver #(
    parameter int unsigned SIZE        = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_serial_in,
    input  logic            i_busy_in,
    input  logic            i_clk_tx_in,
    output logic [SIZE-1:0] o_data_out,
    output logic            o_data_valid,
    input  logic            i_data_ack,
    output logic            o_rx_busy,
    output logic            o_frame_err,
    output logic            o_overrun,
    input  logic            i_clr_overrun
);
    localparam int unsigned CNT_W = $clog2(SIZE + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SIZE - 1);

    typedef enum logic [1:0] {StIdle, StRecv, StDrain} state_t;

    logic [SYNC_STAGES-1:0] r_sync_ser;
    logic [SYNC_STAGES-1:0] r_sync_busy;
    logic [SYNC_STAGES-1:0] r_sync_clk;
    logic                   r_clk_prev;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [SIZE-1:0]  r_shift;
    logic [SIZE-1:0]  r_data;
    logic             r_valid;
    logic             r_rx_busy;
    logic             r_frame_err;
    logic             r_overrun;

    logic             w_ser_s;
    logic             w_busy_s;
    logic             w_clk_s;
    logic             w_sample;
    state_t           w_state_d;
    logic [CNT_W-1:0] w_cnt_d;
    logic [SIZE-1:0]  w_shift_d;
    logic [SIZE-1:0]  w_shift_smp;
    logic [SIZE-1:0]  w_data_d;
    logic             w_valid_d;
    logic             w_overrun_d;
    logic             w_frame_err_d;
    logic             w_complete;
    logic             w_accept;

    assign w_ser_s  = r_sync_ser[SYNC_STAGES-1];
    assign w_busy_s = r_sync_busy[SYNC_STAGES-1];
    assign w_clk_s  = r_sync_clk[SYNC_STAGES-1];
    // Falling edge of the bit clock lands mid-bit, where the line is stable.
    assign w_sample = r_clk_prev & ~w_clk_s;

    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_shift_d     = r_shift;
        w_shift_smp   = {r_shift[SIZE-2:0], w_ser_s};
        w_complete    = 1'b0;
        w_frame_err_d = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_busy_s) begin
                    w_state_d = StRecv;
                    w_cnt_d   = '0;
                end
            end
            StRecv: begin
                if (w_sample) begin
                    w_shift_d = w_shift_smp;
                    w_cnt_d   = r_cnt + CNT_W'(1);
                end
                // The sample is taken before the short-frame check applies.
                if (w_sample && (r_cnt == LAST_CNT)) begin
                    w_complete = 1'b1;
                    w_state_d  = StDrain;
                end else if (!w_busy_s) begin
                    w_frame_err_d = 1'b1;
                    w_state_d     = StIdle;
                end
            end
            StDrain: begin
                if (!w_busy_s) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase

        w_accept    = r_valid & i_data_ack;
        w_valid_d   = r_valid & ~w_accept;
        w_data_d    = r_data;
        w_overrun_d = r_overrun & ~i_clr_overrun;

        if (w_complete) begin
            if (!r_valid || w_accept) begin
                w_data_d  = w_shift_smp;
                w_valid_d = 1'b1;
            end else begin
                w_overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync_ser  <= '0;
            r_sync_busy <= '0;
            r_sync_clk  <= '0;
            r_clk_prev  <= 1'b0;
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_rx_busy   <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sync_ser  <= {r_sync_ser[SYNC_STAGES-2:0], i_serial_in};
            r_sync_busy <= {r_sync_busy[SYNC_STAGES-2:0], i_busy_in};
            r_sync_clk  <= {r_sync_clk[SYNC_STAGES-2:0], i_clk_tx_in};
            r_clk_prev  <= w_clk_s;
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_shift     <= w_shift_d;
            r_data      <= w_data_d;
            r_valid     <= w_valid_d;
            r_rx_busy   <= (w_state_d != StIdle);
            r_frame_err <= w_frame_err_d;
            r_overrun   <= w_overrun_d;
        end
    end

    assign o_data_out   = r_data;
    assign o_data_valid = r_valid;
    assign o_rx_busy    = r_rx_busy;
    assign o_frame_err  = r_frame_err;
    assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_serial_receiver.sv
// Bench for serial_receiver: directed frames plus random traffic, compared every
// cycle against a frame-level model driven by delayed copies of the line.
module tb_serial_receiver;
    localparam int unsigned SIZE = 32;
    localparam int unsigned SS   = 2;

    logic            clk    = 1'b0;
    logic            rst_n  = 1'b0;
    logic            ser    = 1'b0;
    logic            busy   = 1'b0;
    logic            clk_tx = 1'b0;
    logic            ack    = 1'b0;
    logic            clr    = 1'b0;
    logic [SIZE-1:0] data_out;
    logic            valid;
    logic            rx_busy;
    logic            ferr;
    logic            ovr;

    int n_tests  = 0;
    int n_fail   = 0;
    int ferr_cnt = 0;
    bit rnd_hs   = 1'b0;

    always #5 clk = ~clk;

    serial_receiver #(
        .SIZE        (SIZE),
        .SYNC_STAGES (SS)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_serial_in   (ser),
        .i_busy_in     (busy),
        .i_clk_tx_in   (clk_tx),
        .o_data_out    (data_out),
        .o_data_valid  (valid),
        .i_data_ack    (ack),
        .o_rx_busy     (rx_busy),
        .o_frame_err   (ferr),
        .o_overrun     (ovr),
        .i_clr_overrun (clr)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkw(input string name, input logic [SIZE-1:0] act,
                          input logic [SIZE-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: line history per Clk edge, bits collected in a queue.
    logic [SS:0]     hb, hs, hc;
    int              m_mode;  // 0 idle, 1 collecting, 2 waiting for busy to drop
    bit              m_bits[$];
    logic [SIZE-1:0] m_data;
    logic            m_valid, m_ovr, m_ferr, m_rxbusy;

    task automatic model_reset();
        hb = '0; hs = '0; hc = '0;
        m_mode = 0;
        m_bits.delete();
        m_data = '0; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_rxbusy = 1'b0;
    endtask

    task automatic model_step();
        logic            sb, sd, samp, acc, done, drop;
        logic [SIZE-1:0] w;
        sb   = hb[SS-1];
        sd   = hs[SS-1];
        samp = hc[SS] & ~hc[SS-1];
        acc  = m_valid & ack;
        done = 1'b0;
        drop = 1'b0;
        m_ferr = 1'b0;
        case (m_mode)
            0: if (sb) begin
                m_mode = 1;
                m_bits.delete();
            end
            1: begin
                if (samp) m_bits.push_back(sd);
                if (m_bits.size() == int'(SIZE)) begin
                    done   = 1'b1;
                    m_mode = 2;
                end else if (!sb) begin
                    m_ferr = 1'b1;
                    m_mode = 0;
                end
            end
            default: if (!sb) m_mode = 0;
        endcase
        if (done && (!m_valid || acc)) begin
            w = '0;
            foreach (m_bits[i]) w = (w << 1) | SIZE'(m_bits[i]);
            m_data  = w;
            m_valid = 1'b1;
        end else begin
            drop = done;
            if (acc) m_valid = 1'b0;
        end
        m_ovr    = drop | (m_ovr & ~clr);
        m_rxbusy = (m_mode != 0);
        hb = {hb[SS-1:0], busy};
        hs = {hs[SS-1:0], ser};
        hc = {hc[SS-1:0], clk_tx};
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            check1("cyc valid", valid, m_valid);
            checkw("cyc data", data_out, m_data);
            check1("cyc rx_busy", rx_busy, m_rxbusy);
            check1("cyc frame_err", ferr, m_ferr);
            check1("cyc overrun", ovr, m_ovr);
            if (ferr) ferr_cnt++;
        end
    end

    task automatic tick();
        @(negedge clk);
        if (rnd_hs) begin
            ack = ($urandom_range(0, 5) == 0);
            clr = ($urandom_range(0, 15) == 0);
        end
    endtask

    // One bit period = 8 Clk cycles; line changes on the bit-clock rising edge.
    task automatic bit_period(input logic b, input logic d, input bit ack_at_fall);
        tick();
        clk_tx = 1'b1;
        busy   = b;
        ser    = d;
        repeat (3) tick();
        tick();
        clk_tx = 1'b0;
        if (ack_at_fall) begin
            // Ack lands on the edge where this bit's sample completes the word.
            repeat (SS) tick();
            ack = 1'b1;
            tick();
            ack = 1'b0;
            repeat (3 - SS - 1) tick();
        end else begin
            repeat (3) tick();
        end
    endtask

    task automatic send_frame(input logic [SIZE-1:0] w, input int nbits, input bit ack_last,
                              input int gap);
        for (int i = 0; i < nbits; i++) begin
            bit_period(1'b1, (i < int'(SIZE)) ? w[SIZE-1-i] : 1'($urandom_range(0, 1)),
                       ack_last && (i == int'(SIZE) - 1));
        end
        for (int i = 0; i < gap; i++) bit_period(1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_ack();
        tick(); ack = 1'b1;
        tick(); ack = 1'b0;
        tick();
    endtask

    initial begin
        int f0;
        int kind;
        int nb;
        logic [SIZE-1:0] w;

        repeat (3) tick();
        check1("reset valid", valid, 1'b0);
        checkw("reset data", data_out, '0);
        check1("reset rx_busy", rx_busy, 1'b0);
        check1("reset frame_err", ferr, 1'b0);
        check1("reset overrun", ovr, 1'b0);
        rst_n = 1'b1;
        repeat (4) tick();

        // Single frame, no ack.
        send_frame(32'hA5C3_0F96, SIZE + 1, 1'b0, 2);
        checkw("single data", data_out, 32'hA5C3_0F96);
        check1("single valid", valid, 1'b1);
        check1("single overrun", ovr, 1'b0);
        check1("single rx_busy", rx_busy, 1'b0);
        checki("single frame_err count", ferr_cnt, 0);
        pulse_ack();
        check1("single ack clears valid", valid, 1'b0);

        // Back-to-back with ack.
        send_frame(32'hFFFF_FFFF, SIZE + 1, 1'b0, 2);
        checkw("b2b first data", data_out, 32'hFFFF_FFFF);
        pulse_ack();
        send_frame(32'h0000_0001, SIZE + 1, 1'b0, 2);
        checkw("b2b second data", data_out, 32'h0000_0001);
        check1("b2b second valid", valid, 1'b1);
        check1("b2b overrun", ovr, 1'b0);
        pulse_ack();

        // Overrun.
        send_frame(32'h1234_5678, SIZE + 1, 1'b0, 2);
        send_frame(32'h9ABC_DEF0, SIZE + 1, 1'b0, 2);
        checkw("overrun data kept", data_out, 32'h1234_5678);
        check1("overrun flag", ovr, 1'b1);
        check1("overrun valid", valid, 1'b1);
        tick(); clr = 1'b1;
        tick(); clr = 1'b0;
        tick();
        check1("overrun cleared", ovr, 1'b0);
        pulse_ack();
        check1("overrun ack valid", valid, 1'b0);

        // Short frame then a good one, left unacknowledged.
        f0 = ferr_cnt;
        send_frame(32'hFFFF_FFFF, 10, 1'b0, 2);
        checki("short frame_err pulses", ferr_cnt, f0 + 1);
        check1("short valid", valid, 1'b0);
        check1("short rx_busy", rx_busy, 1'b0);
        send_frame(32'h0F0F_0F0F, SIZE + 1, 1'b0, 2);
        checkw("after short data", data_out, 32'h0F0F_0F0F);
        check1("after short valid", valid, 1'b1);

        // Reset mid-frame, between clock edges.
        f0 = ferr_cnt;
        for (int i = 0; i < 16; i++) bit_period(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        check1("pre-reset rx_busy", rx_busy, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check1("async reset valid", valid, 1'b0);
        checkw("async reset data", data_out, '0);
        check1("async reset rx_busy", rx_busy, 1'b0);
        check1("async reset overrun", ovr, 1'b0);
        busy = 1'b0; ser = 1'b0; clk_tx = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        send_frame(32'hDEAD_BEEF, SIZE + 1, 1'b0, 2);
        checkw("post-reset data", data_out, 32'hDEAD_BEEF);
        checki("post-reset frame_err count", ferr_cnt, f0);
        pulse_ack();

        // Ack in the same cycle the second word completes.
        send_frame(32'h1357_9BDF, SIZE + 1, 1'b0, 2);
        send_frame(32'h2468_ACE0, SIZE + 1, 1'b1, 2);
        checkw("collision data", data_out, 32'h2468_ACE0);
        check1("collision valid", valid, 1'b1);
        check1("collision overrun", ovr, 1'b0);
        pulse_ack();

        // Random traffic with random ack/clear.
        rnd_hs = 1'b1;
        for (int n = 0; n < 24; n++) begin
            kind = $urandom_range(0, 4);
            w    = $urandom;
            nb   = (kind == 0) ? $urandom_range(1, SIZE - 1) :
                   (kind == 1) ? int'(SIZE) : int'(SIZE) + 1;
            send_frame(w, nb, 1'b0, $urandom_range(1, 3));
        end
        rnd_hs = 1'b0;
        ack    = 1'b0;
        clr    = 1'b0;
        repeat (8) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_receiver.md
Name: serial_receiver

Overview:
- Serial-in/parallel-out receiver, one stage downstream of the serial transceiver (PISO).
- Consumes the transceiver's serial data, busy flag and bit clock, all oversampled in the local Clk domain.
- Rebuilds the SIZE-bit word, MSB first, and presents it on a valid/ack handshake to the next stage.
- Flags frame errors (busy dropped early) and overrun (new word while the previous one is unacknowledged).

Parameters:
- SIZE, 32, word width in bits; must be >= 2.
- SYNC_STAGES, 2, synchronizer depth for SerialIn, BusyIn and ClkTxIn; must be >= 2.

Ports:
- Clk  input  1  system clock; frequency >= 4x ClkTxIn frequency.
- Reset  input  1  asynchronous, active-low reset.
- SerialIn  input  1  serial data from the transceiver Dout; changes on ClkTxIn rising edge.
- BusyIn  input  1  transceiver TxBusy; high while a frame is on the line.
- ClkTxIn  input  1  transceiver bit clock, treated as data and sampled by Clk.
- DataOut  output  SIZE  received word; stable while DataValid = 1.
- DataValid  output  1  word available; held until accepted.
- DataAck  input  1  consumer accepts the word when DataValid & DataAck at a Clk edge.
- RxBusy  output  1  high while a frame is being assembled.
- FrameErr  output  1  one-cycle pulse on a short frame.
- Overrun  output  1  sticky overrun flag.
- ClrOverrun  input  1  clears Overrun (synchronous, single cycle).

Behaviour:
- Reset (Reset = 0, async): all outputs 0; state IDLE; bit counter 0; shift register 0; synchronizers 0.
- Synchronize SerialIn, BusyIn and ClkTxIn through SYNC_STAGES flops.
- Bit-sample event = falling edge of synchronized ClkTxIn (current 0, previous 1), i.e. mid-bit.
- Latency: a sample occurs 1 + SYNC_STAGES Clk cycles after the raw ClkTxIn falls.
- FSM, IDLE:
  - On synced BusyIn = 1, go to RECV.
  - Clear the bit counter and set RxBusy = 1 in the same cycle.
- FSM, RECV:
  - On each sample event: shift register <= {shift[SIZE-2:0], syncSerialIn}; counter + 1.
  - When the counter reaches SIZE on a sample event, the word is complete: go to DRAIN.
  - If synced BusyIn falls before the counter reaches SIZE: FrameErr = 1 for one cycle, partial word discarded, DataOut unchanged, go to IDLE.
  - A sample event and a BusyIn fall in the same cycle: the sample is taken first, then the completion check is applied.
- Word completion (entry into DRAIN):
  - If DataValid = 0, or DataValid & DataAck in this same cycle: DataOut <= assembled word, DataValid = 1 next cycle.
  - Otherwise: the new word is dropped, DataOut is kept, and Overrun <= 1.
- FSM, DRAIN:
  - Ignore further sample events; the transceiver emits SIZE+1 bit periods and the extra trailing bit is discarded.
  - RxBusy stays 1.
  - When synced BusyIn = 0: RxBusy = 0, go to IDLE.
- Handshake:
  - DataValid clears on the Clk edge where DataValid & DataAck.
  - DataAck while DataValid = 0 is ignored.
  - DataOut never changes while DataValid = 1.
- Overrun:
  - Set on a dropped word; stays set until ClrOverrun = 1.
  - ClrOverrun and a new overrun in the same cycle: set wins.
- BusyIn rising while in DRAIN is not possible by protocol; if it occurs it is treated as a continuation of the current frame (no new frame is started).
- Reset mid-frame: immediate abort, no FrameErr, all outputs back to reset values.
- Counter width: $clog2(SIZE+1) bits; it never wraps because DRAIN blocks counting.

Test Plan:
- Single frame: SIZE=32, send 0xA5C3_0F96 MSB first with ClkTx = Clk/8 and BusyIn high for 33 bit periods, DataAck held 0 -> DataValid=1 with DataOut=0xA5C3_0F96; FrameErr=0; Overrun=0; RxBusy falls after BusyIn falls.
- Back-to-back with ack: frames 0xFFFF_FFFF then 0x0000_0001, DataAck pulsed after each DataValid -> two valid words in order, with no Overrun.
- Overrun: two frames 0x1234_5678 and 0x9ABC_DEF0, DataAck held 0 -> DataOut stays 0x1234_5678 and Overrun=1; ClrOverrun pulse -> Overrun=0; DataAck -> DataValid=0.
- Short frame: BusyIn dropped after 10 bits -> one-cycle FrameErr, DataValid stays 0, state returns to IDLE; the next full frame 0x0F0F_0F0F is received correctly.
- Reset mid-frame: Reset=0 after 16 bits -> all outputs 0 asynchronously, with no FrameErr; after release, a full frame 0xDEAD_BEEF is received correctly.
- Ack collision: DataAck asserted in the same cycle the second word completes -> the second word is loaded, DataValid stays 1, and Overrun=0.
